// File: rtl/quant_param_stream.sv
// quant_param_stream
//   Buffers one layer's per-column requantization parameters {bias, m, e}
//   and replays them, row after row, as three independent AXI-stream
//   channels feeding the bias, m and e inputs of the requantization stage.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   start               one-cycle layer start pulse (ignored unless idle)
//   cfg_cols, cfg_rows  layer geometry, sampled on start
//   in_cfg_*            parameter load stream, tdata = {bias, m, e}
//   out_bias_*          bias replay stream
//   out_m_*             multiplier replay stream
//   out_e_*             shift replay stream
//   busy                high while loading or replaying
//   done                one-cycle pulse when the layer completes
//   err                 sticky: in_cfg tlast seen at the wrong beat

// One replay channel: walks col 0..cols-1 for every row and keeps its own
// output register, so it never waits on its sibling channels.
module quant_param_chan #(
  parameter int W     = 8,
  parameter int IW    = 6,
  parameter int ROW_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [IW-1:0]    cols_m1,
  input  logic [ROW_W-1:0] rows_m1,
  input  logic [W-1:0]     rd_data,
  output logic [IW-1:0]    col,
  output logic [W-1:0]     tdata,
  output logic             tvalid,
  output logic             tlast,
  input  logic             tready,
  output logic             fin_next
);
  logic [ROW_W-1:0] row;
  logic             issued;  // final beat has been placed in the output register
  logic             fin;
  logic             hs;
  logic             load_en;

  assign hs       = tvalid & tready;
  assign load_en  = run & ~issued & (tready | ~tvalid);
  // Finished now, or finishing on this edge's handshake of the final beat.
  assign fin_next = fin | (issued & hs);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col    <= '0;
      row    <= '0;
      issued <= 1'b0;
      fin    <= 1'b0;
      tdata  <= '0;
      tvalid <= 1'b0;
      tlast  <= 1'b0;
    end else if (!run) begin
      col    <= '0;
      row    <= '0;
      issued <= 1'b0;
      fin    <= 1'b0;
      tvalid <= 1'b0;
    end else if (load_en) begin
      tdata  <= rd_data;
      tlast  <= (col == cols_m1);
      tvalid <= 1'b1;
      if (col == cols_m1) begin
        col <= '0;
        if (row == rows_m1) issued <= 1'b1;
        else                row    <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end else if (hs) begin
      // Only reachable once the final beat is issued: drain and stop.
      tvalid <= 1'b0;
      fin    <= 1'b1;
    end
  end
endmodule

module quant_param_stream #(
  parameter int D_W      = 8,
  parameter int D_W_ACC  = 32,
  parameter int MAX_COLS = 64,
  parameter int ROW_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(MAX_COLS+1)-1:0] cfg_cols,
  input  logic [ROW_W-1:0]             cfg_rows,
  input  logic [2*D_W_ACC+D_W-1:0]     in_cfg_tdata,
  input  logic                         in_cfg_tvalid,
  output logic                         in_cfg_tready,
  input  logic                         in_cfg_tlast,
  output logic [D_W_ACC-1:0]           out_bias_tdata,
  output logic                         out_bias_tvalid,
  input  logic                         out_bias_tready,
  output logic                         out_bias_tlast,
  output logic [D_W_ACC-1:0]           out_m_tdata,
  output logic                         out_m_tvalid,
  input  logic                         out_m_tready,
  output logic                         out_m_tlast,
  output logic [D_W-1:0]               out_e_tdata,
  output logic                         out_e_tvalid,
  input  logic                         out_e_tready,
  output logic                         out_e_tlast,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);
  localparam int CW = $clog2(MAX_COLS+1);
  localparam int IW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam int PW = 2*D_W_ACC + D_W;
  localparam logic [CW-1:0] MAX_C = CW'(MAX_COLS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    cols_m1_q;
  logic [ROW_W-1:0] rows_m1_q;
  logic [IW-1:0]    load_idx_q;
  logic             err_q, done_q, done_d;
  logic             run;
  logic             in_hs;
  logic [CW-1:0]    cols_clamped;
  logic [2:0]       fin_next;
  logic [IW-1:0]    col_b, col_m, col_e;
  logic [PW-1:0]    buf_mem [MAX_COLS];

  assign cols_clamped = (cfg_cols > MAX_C) ? MAX_C : cfg_cols;
  assign in_hs        = in_cfg_tvalid & in_cfg_tready;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign err          = err_q;

  // NOTE: registers take non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d       = state_q;
    done_d        = 1'b0;
    in_cfg_tready = 1'b0;
    run           = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_cols == '0 || cfg_rows == '0) done_d  = 1'b1;
          else                                  state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        in_cfg_tready = 1'b1;
        if (in_cfg_tvalid && load_idx_q == cols_m1_q) state_d = S_RUN;
      end
      S_RUN: begin
        run = 1'b1;
        if (&fin_next) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cols_m1_q  <= '0;
      rows_m1_q  <= '0;
      load_idx_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= done_d;
      if (state_q == S_IDLE && start) begin
        err_q      <= 1'b0;
        cols_m1_q  <= IW'(cols_clamped - 1'b1);
        rows_m1_q  <= cfg_rows - 1'b1;
        load_idx_q <= '0;
      end else if (in_hs) begin
        // tlast must be set on the last beat and only there.
        if (in_cfg_tlast != (load_idx_q == cols_m1_q)) err_q <= 1'b1;
        load_idx_q <= load_idx_q + 1'b1;
      end
    end
  end

  // NOTE: the parameter buffer has no reset; every layer reloads the
  // entries it replays, so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (in_hs) buf_mem[load_idx_q] <= in_cfg_tdata;
  end

  quant_param_chan #(.W(D_W_ACC), .IW(IW), .ROW_W(ROW_W)) u_bias (
    .clk, .rst, .run, .cols_m1(cols_m1_q), .rows_m1(rows_m1_q),
    .rd_data (buf_mem[col_b][PW-1 -: D_W_ACC]),
    .col     (col_b),
    .tdata   (out_bias_tdata),
    .tvalid  (out_bias_tvalid),
    .tlast   (out_bias_tlast),
    .tready  (out_bias_tready),
    .fin_next(fin_next[0])
  );

  quant_param_chan #(.W(D_W_ACC), .IW(IW), .ROW_W(ROW_W)) u_m (
    .clk, .rst, .run, .cols_m1(cols_m1_q), .rows_m1(rows_m1_q),
    .rd_data (buf_mem[col_m][D_W +: D_W_ACC]),
    .col     (col_m),
    .tdata   (out_m_tdata),
    .tvalid  (out_m_tvalid),
    .tlast   (out_m_tlast),
    .tready  (out_m_tready),
    .fin_next(fin_next[1])
  );

  quant_param_chan #(.W(D_W), .IW(IW), .ROW_W(ROW_W)) u_e (
    .clk, .rst, .run, .cols_m1(cols_m1_q), .rows_m1(rows_m1_q),
    .rd_data (buf_mem[col_e][D_W-1:0]),
    .col     (col_e),
    .tdata   (out_e_tdata),
    .tvalid  (out_e_tvalid),
    .tlast   (out_e_tlast),
    .tready  (out_e_tready),
    .fin_next(fin_next[2])
  );
endmodule

// File: tb/tb_quant_param_stream.sv
// Self-checking bench for quant_param_stream: directed layers with
// hand-chosen parameter tables, per-beat data/tlast comparison, stall
// stability, latency and done/err behaviour.
module tb_quant_param_stream;
  localparam int D_W      = 8;
  localparam int D_W_ACC  = 32;
  localparam int MAX_COLS = 64;
  localparam int ROW_W    = 16;
  localparam int CW       = $clog2(MAX_COLS+1);

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     start = 1'b0;
  logic [CW-1:0]            cfg_cols = '0;
  logic [ROW_W-1:0]         cfg_rows = '0;
  logic [2*D_W_ACC+D_W-1:0] in_cfg_tdata = '0;
  logic                     in_cfg_tvalid = 1'b0;
  logic                     in_cfg_tready;
  logic                     in_cfg_tlast = 1'b0;
  logic [D_W_ACC-1:0]       out_bias_tdata, out_m_tdata;
  logic [D_W-1:0]           out_e_tdata;
  logic                     out_bias_tvalid, out_m_tvalid, out_e_tvalid;
  logic                     out_bias_tlast, out_m_tlast, out_e_tlast;
  logic                     out_bias_tready = 1'b1;
  logic                     out_m_tready = 1'b1;
  logic                     out_e_tready = 1'b1;
  logic                     busy, done, err;

  quant_param_stream #(.D_W(D_W), .D_W_ACC(D_W_ACC), .MAX_COLS(MAX_COLS), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .in_cfg_tdata(in_cfg_tdata), .in_cfg_tvalid(in_cfg_tvalid),
    .in_cfg_tready(in_cfg_tready), .in_cfg_tlast(in_cfg_tlast),
    .out_bias_tdata(out_bias_tdata), .out_bias_tvalid(out_bias_tvalid),
    .out_bias_tready(out_bias_tready), .out_bias_tlast(out_bias_tlast),
    .out_m_tdata(out_m_tdata), .out_m_tvalid(out_m_tvalid),
    .out_m_tready(out_m_tready), .out_m_tlast(out_m_tlast),
    .out_e_tdata(out_e_tdata), .out_e_tvalid(out_e_tvalid),
    .out_e_tready(out_e_tready), .out_e_tlast(out_e_tlast),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Parameter tables driven on in_cfg, beat k = {lb[k], lm[k], le[k]}.
  int lb [0:79];
  int lm [0:79];
  int le [0:79];

  // Results of the last layer run.
  int          c_done, c_last_load, c_first_v, n_in;
  int          nrec [3];
  int          last_hs_c [3];
  logic [32:0] rec [3][0:255];
  bit          any_busy, any_valid;
  string       nm [3] = '{"bias", "m", "e"};

  task automatic set_basic();
    for (int i = 0; i < 4; i++) begin
      lb[i] = 10 * (i + 1);
      lm[i] = i + 1;
      le[i] = i;
    end
  endtask

  // Runs one layer. tlast_at < 0 drives tlast on the correct beat;
  // mode 1 applies m toggling and a 5-cycle e stall; rst_after > 0 pulls
  // reset once that many bias beats have been handshaken.
  task automatic run_layer(input int ccols, input int crows, input int nbeats,
                           input int tlast_at, input int mode, input int rst_after,
                           input bit exp_err);
    int          c, k, e_seen, ceff, nexp, hs_max;
    bit          stop;
    logic [2:0]  rdy, ov, ol;
    logic [31:0] od [3];
    bit          pstall [3];
    logic        pl [3];
    logic [31:0] pd [3];
    logic [31:0] expd;

    ceff = (ccols > MAX_COLS) ? MAX_COLS : ccols;
    c_done = -1; c_last_load = -100; c_first_v = -1; n_in = 0;
    any_busy = 0; any_valid = 0; stop = 0;
    for (int i = 0; i < 3; i++) begin
      nrec[i] = 0; last_hs_c[i] = -1; pstall[i] = 0; pl[i] = 0; pd[i] = '0;
    end

    @(negedge clk);
    start = 1'b1;
    cfg_cols = CW'(ccols);
    cfg_rows = ROW_W'(crows);
    c = 0; k = 0; e_seen = 0;
    while (c < 3000 && !stop) begin
      if (c >= 1) start = 1'b0;
      if (c == 1) begin
        if (ceff > 0 && crows > 0) begin
          check("busy_after_start", busy, 1);
          check("tready_after_start", in_cfg_tready, 1);
          check("err_cleared_by_start", err, 0);
        end else begin
          check("degen_done_pulse", done, 1);
          check("degen_busy", busy, 0);
          check("degen_tready", in_cfg_tready, 0);
        end
      end
      if (ceff > 0 && n_in == ceff && c == c_last_load + 1)
        check("tready_drop_after_load", in_cfg_tready, 0);

      in_cfg_tvalid = (k < nbeats);
      in_cfg_tdata  = {lb[k][31:0], lm[k][31:0], le[k][7:0]};
      in_cfg_tlast  = (tlast_at < 0) ? (k == ceff - 1) : (k == tlast_at);
      rdy[0] = 1'b1;
      rdy[1] = (mode == 1) ? c[0] : 1'b1;
      rdy[2] = (mode == 1) ? (e_seen >= 5) : 1'b1;
      out_bias_tready = rdy[0];
      out_m_tready    = rdy[1];
      out_e_tready    = rdy[2];

      ov = {out_e_tvalid, out_m_tvalid, out_bias_tvalid};
      ol = {out_e_tlast, out_m_tlast, out_bias_tlast};
      od[0] = out_bias_tdata;
      od[1] = out_m_tdata;
      od[2] = {24'b0, out_e_tdata};
      if (busy) any_busy = 1;
      if (|ov)  any_valid = 1;
      if (ov[0] && c_first_v < 0) c_first_v = c;

      if (in_cfg_tvalid && in_cfg_tready) begin
        n_in++;
        c_last_load = c;
        k++;
      end
      for (int i = 0; i < 3; i++) begin
        if (pstall[i])
          check({nm[i], "_stall_hold"}, {ov[i], ol[i], od[i]}, {1'b1, pl[i], pd[i]});
        if (ov[i] && rdy[i]) begin
          rec[i][nrec[i]] = {ol[i], od[i]};
          nrec[i]++;
          last_hs_c[i] = c;
        end
        pstall[i] = ov[i] & ~rdy[i];
        pl[i] = ol[i];
        pd[i] = od[i];
      end
      if (mode == 1 && ov[2] && !rdy[2]) e_seen++;

      if (done) begin
        c_done = c;
        stop = 1;
      end else if (rst_after > 0 && nrec[0] >= rst_after) begin
        rst = 1'b0;
        #1;
        check("rst_bias_tvalid", out_bias_tvalid, 0);
        check("rst_m_tvalid", out_m_tvalid, 0);
        check("rst_e_tvalid", out_e_tvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_tready", in_cfg_tready, 0);
        @(negedge clk);
        rst = 1'b1;
        stop = 1;
      end else begin
        @(negedge clk);
        c++;
      end
    end

    in_cfg_tvalid = 1'b0;
    out_bias_tready = 1'b1;
    out_m_tready = 1'b1;
    out_e_tready = 1'b1;
    if (rst_after > 0) return;

    check("done_seen", (c_done >= 0), 1);
    if (ceff == 0 || crows == 0) begin
      check("degen_done_cycle", c_done, 1);
      check("degen_no_load", n_in, 0);
      check("degen_no_tvalid", any_valid, 0);
      check("degen_never_busy", any_busy, 0);
    end else begin
      nexp = ceff * crows;
      check("load_beats", n_in, ceff);
      check("err_flag", err, exp_err);
      check("first_valid_latency", c_first_v - c_last_load, 2);
      check("busy_low_at_done", busy, 0);
      hs_max = 0;
      for (int i = 0; i < 3; i++) begin
        check({nm[i], "_beat_count"}, nrec[i], nexp);
        for (int j = 0; j < nrec[i] && j < nexp; j++) begin
          int col;
          col = j % ceff;
          expd = (i == 0) ? lb[col] : (i == 1) ? lm[col] : (le[col] & 255);
          check({nm[i], "_beat"}, rec[i][j], {(col == ceff - 1), expd});
        end
        if (mode == 0) check({nm[i], "_final_hs"}, last_hs_c[i] - c_last_load, 1 + nexp);
        if (last_hs_c[i] > hs_max) hs_max = last_hs_c[i];
      end
      check("done_after_last_stream", c_done, hs_max + 1);
    end
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_tready", in_cfg_tready, 0);
    check("reset_tvalid", {out_bias_tvalid, out_m_tvalid, out_e_tvalid}, 0);
    check("reset_tlast", {out_bias_tlast, out_m_tlast, out_e_tlast}, 0);
    check("reset_tdata", {out_bias_tdata, out_e_tdata}, 0);
    rst = 1'b1;
    @(negedge clk);

    // Basic: bias 10..40, m 1..4, e 0..3, two rows, all ready.
    set_basic();
    run_layer(4, 2, 4, -1, 0, 0, 0);
    // Final load edge to done rising edge.
    check("basic_done_latency", c_done - c_last_load - 1, 9);
    check("basic_bias_beat5", rec[0][5], {1'b0, 32'd20});
    check("basic_m_beat7", rec[1][7], {1'b1, 32'd4});
    check("basic_e_beat3", rec[2][3], {1'b1, 32'd3});

    // Independent backpressure on m and e.
    run_layer(4, 2, 4, -1, 1, 0, 0);
    check("bp_e_last_finishes", (last_hs_c[2] > last_hs_c[0]), 1);

    // tlast early on beat 1 of a 3-column load.
    lb[0] = 5;  lb[1] = 6;   lb[2] = 7;
    lm[0] = 100; lm[1] = 200; lm[2] = 300;
    le[0] = 9;  le[1] = 8;   le[2] = 7;
    run_layer(3, 2, 3, 1, 0, 0, 1);

    // Degenerate geometry (also clears err from the previous layer).
    run_layer(0, 2, 4, -1, 0, 0, 0);
    run_layer(4, 0, 4, -1, 0, 0, 0);
    check("err_cleared_degen", err, 0);

    // Clamp to MAX_COLS with 70 offered beats, three rows.
    for (int i = 0; i < 80; i++) begin
      lb[i] = 1000 + i;
      lm[i] = 7 * i;
      le[i] = 100 + i;
    end
    run_layer(70, 3, 70, -1, 0, 0, 0);

    // Reset mid-run, then a clean basic layer.
    set_basic();
    run_layer(4, 2, 4, -1, 0, 5, 0);
    @(negedge clk);
    run_layer(4, 2, 4, -1, 0, 0, 0);
    check("post_reset_done_latency", c_done - c_last_load - 1, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/quant_param_stream.md
# quant_param_stream

Sequencer that buffers one layer's per-column requantization parameters (bias, multiplier m, shift e) and replays them as three independent AXI-stream channels, one entry per output element. It feeds the bias, m and e inputs of the requantization stage, in lock-step with the accumulator stream on that stage's A input. Parameters are loaded once per layer and replayed row after row. This removes per-element parameter traffic from the memory fabric.

## Interface
Parameters:
- D_W, 8: width of shift value e (signed).
- D_W_ACC, 32: width of bias and m (signed).
- MAX_COLS, 64: parameter buffer depth; maximum columns per layer.
- ROW_W, 16: width of the row-count input.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a layer; ignored unless the block is idle.
- cfg_cols  in  $clog2(MAX_COLS+1)  column count; sampled on start.
- cfg_rows  in  ROW_W  row count; sampled on start.
- in_cfg  axi_stream_if.axi_in  tdata 2*D_W_ACC+D_W  packed {bias, m, e}; bias in the MSBs. Carries tvalid, tready, tlast.
- out_bias  axi_stream_if.axi_out  tdata D_W_ACC  bias stream, with tvalid, tready, tlast.
- out_m  axi_stream_if.axi_out  tdata D_W_ACC  multiplier stream.
- out_e  axi_stream_if.axi_out  tdata D_W  shift stream.
- busy  out  1  high in LOAD or RUN.
- done  out  1  one-cycle pulse when the layer completes.
- err  out  1  sticky flag: in_cfg tlast did not match the expected position. Cleared by start or reset.

## Operation
- FSM states: IDLE, LOAD, RUN.
  - IDLE to LOAD on start when cols>0 and rows>0.
  - LOAD to RUN on acceptance of beat cols-1.
  - RUN to IDLE when all three output streams have finished.
- Latched cols = min(cfg_cols, MAX_COLS).
- If cols==0 or rows==0 on start, the block stays in IDLE and pulses done on the next cycle.
- LOAD:
  - in_cfg.tready=1 only in LOAD.
  - Beat k (k=0..cols-1) is written to buffer index k.
  - err is set if tlast=1 at k<cols-1, or if tlast=0 at k=cols-1.
  - Load always ends after exactly cols beats.
- RUN:
  - Each output stream has its own column counter (0..cols-1), row counter (0..rows-1), output register and finished flag.
  - Streams advance independently; no stream waits for another.
  - A stream's output register loads when (tready | ~tvalid) and the stream is not finished.
  - tdata is the field of buffer[col] for that stream.
  - tlast=1 when col==cols-1, i.e. at the end of every row.
  - The column counter wraps to 0 after cols-1, and the row counter then increments.
  - After the handshake of beat (rows-1, cols-1), the stream drops tvalid and sets its finished flag.
- All arithmetic is unsigned counter math. Data passes through bit-exact, with no sign handling.
- Buffer: MAX_COLS x (2*D_W_ACC+D_W). Reads are combinational from registers or distributed RAM. A synchronous-read RAM is allowed only if the timing below is preserved.
- start in LOAD or RUN is ignored. The buffer keeps its contents across layers, but every start requires a fresh load.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE; busy=0, done=0, err=0.
  - All out_*.tvalid=0, tlast=0, tdata=0.
  - in_cfg.tready=0.
  - Counters cleared.
- start sampled high at edge t: busy=1 and in_cfg.tready=1 from t+1.
- Last load beat accepted at edge L: state=RUN at L+1, in_cfg.tready=0 at L+1, first out_*.tvalid=1 at L+2.
- Throughput is 1 beat per cycle per stream under continuous tready.
- With all treadys held high, a stream's final handshake occurs at L+1+rows*cols.
- done pulses one cycle after the edge on which the last of the three streams finishes. busy=0 in that same cycle.
- Backpressure: when tready=0 and tvalid=1, tdata and tlast are held stable until the handshake.
- Reset asserted mid-operation returns the block to its reset values immediately. Buffer contents are don't-care afterwards.

## Test plan
- Basic: cols=4, rows=2; load bias={10,20,30,40}, m={1,2,3,4}, e={0,1,2,3}, tlast on beat 3; all treadys=1. Required: each stream emits 10,20,30,40,10,20,30,40 (likewise for m and e); tlast on beats 3 and 7; done 9 cycles after the final load beat.
- Independent backpressure: same load; out_m.tready toggles every other cycle, out_e.tready=0 for 5 cycles. Required: each stream's sequence is identical to the basic case; data is stable while stalled; done fires only after the out_e final beat.
- Load tlast error: cols=3, tlast asserted on beat 1. Required: err=1; load still consumes 3 beats; replay is correct; the next start clears err.
- Degenerate: start with cfg_cols=0, then with cfg_rows=0. Required: no in_cfg.tready, no tvalid, done pulse at t+1, busy stays 0.
- Clamp and wrap: MAX_COLS=64, cfg_cols=70, rows=3. Required: exactly 64 load beats accepted; 192 beats per stream; tlast every 64th beat.
- Reset mid-RUN: rst=0 after 5 output beats. Required: all tvalid=0 and state IDLE in the same cycle; a new start/load/run after reset behaves as in the basic case.
